fp_stream_adapter: RTL and testbench
====================================

# fp_stream_adapter

Valid/ready streaming front-end for a fixed-latency, clock-enable-gated floating-point operator core such as the generated single-precision multipliers.
- Accepts operand pairs on a handshake, issues them to the core and tracks in-flight operations with a tag shift register.
- Captures each core result into an output FIFO and returns it on a second handshake.
- Credit accounting guarantees no result is ever dropped, so the core pipeline never needs stalling.
- The core is instantiated beside this block at the parent level; the adapter drives its operand and enable inputs and samples its result output.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- LATENCY, 5, core latency: result valid on core_dout after the LATENCY-th rising edge, counting the operand-sampling edge as the first; legal range 1..16
- DEPTH, 8, output FIFO entries; must be ≥ 2, power of two

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- in_valid  in  1  operand pair offered
- in_ready  out  1  adapter can accept
- in_a  in  WIDTH  first operand
- in_b  in  WIDTH  second operand
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  result
- core_ce  out  1  core clock enable
- core_din0  out  WIDTH  to core din0
- core_din1  out  WIDTH  to core din1
- core_dout  in  WIDTH  from core dout
- out_count  out  16  only with FP_STREAM_STATS_EN

## Operation
- core_din0 = in_a and core_din1 = in_b (combinational pass-through); the core samples them on the issue edge.
- Issue = in_valid && in_ready at a rising edge.
- tag[1..LATENCY] shift register:
  - tag[1] <= issue; tag[i] <= tag[i-1] every cycle.
  - tag[LATENCY]=1 means core_dout currently holds a valid result.
  - That result is pushed into the FIFO on the next edge.
- inflight = popcount of tag bits; occupancy = fifo_count + inflight.
- in_ready = core_ce && (occupancy < DEPTH). Every issued op therefore has a reserved FIFO slot; push never meets a full FIFO.
- Pop = out_valid && out_ready. Push and pop in the same cycle are legal and leave fifo_count unchanged.
- Results leave in issue order; data is never altered.
- core_ce: 0 in reset, then 1 from the first edge after reset release and held there. The core is never stalled.
- Reset mid-operation:
  - Tags and FIFO pointers are cleared, so in-flight results are discarded.
  - Any garbage left in the core pipeline is ignored because its tags are 0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, core_ce=0, out_count=0.
- in_ready rises one cycle after reset release, when core_ce goes high.
- Issue at edge E → push at edge E+LATENCY → out_valid high after edge E+LATENCY, i.e. LATENCY+1 edges counting E.
- Back-to-back: one issue per cycle sustained while out_ready=1; throughput 1/cycle.
- Backpressure:
  - With out_ready=0, exactly DEPTH ops are accepted, then in_ready=0.
  - in_ready reasserts the cycle after the first pop.
- FIFO pointers have an extra wrap bit. full/empty are distinguished by that bit; wrap-around at DEPTH is seamless.
- out_data and out_valid are registered (FIFO head); no combinational path from in_* to out_*.

## Configuration
- FP_STREAM_STATS_EN defined: port out_count exists.
  - 16-bit counter, +1 per pop, wraps 0xFFFF→0x0000, reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package fp_stream_pkg:
  - default WIDTH and DEPTH constants
  - function returning pointer width (clog2(DEPTH)+1)
  - MAX_LATENCY=16 constant
- One sub-module, fp_stream_fifo: synchronous FIFO with registered head, push/pop/count ports, same clock and reset.
- Top contains only the tag shift register, occupancy logic, core_ce register and the optional counter.

## Test plan
Benches use a behavioral fmul core model with LATENCY=5 unless noted.
- Single op: in_a=0x40000000, in_b=0x40800000 issued at edge 1 → out_valid after edge 6, out_data=0x41000000.
- Stream of 20 ops with out_ready=1 → in_ready never drops after start-up; 20 results in order, the first 6 cycles after the first issue.
- Backpressure, out_ready=0 with 12 ops offered:
  - exactly 8 accepted, then in_ready=0;
  - after out_ready=1, all 8 drain in order and the remaining 4 are accepted.
- Simultaneous push/pop at the FIFO full boundary with pointer wrap (≥3·DEPTH ops, out_ready toggled each cycle) → no loss or duplication.
- Reset pulled low with 3 ops in flight and 2 in the FIFO:
  - outputs go to reset values immediately;
  - after release, no stale result ever appears;
  - a new op 0x3F800000×0x3F800000 → 0x3F800000.
- FP_STREAM_STATS_EN: 70000 pops → out_count = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/fp_stream_pkg.sv
// ---------------------------------------------------------------------------
// fp_stream_pkg
// Shared constants and helpers for the floating-point stream adapter:
//   DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_LATENCY : parameter defaults
//   MAX_LATENCY                                     : deepest supported core
//   ptr_width(depth)                                : FIFO pointer width,
//                                                     address bits + wrap bit
// ---------------------------------------------------------------------------
package fp_stream_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_LATENCY = 5;
  localparam int MAX_LATENCY     = 16;

  // One extra bit above the address so that full and empty differ only in
  // the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fp_stream_fifo.sv
// ---------------------------------------------------------------------------
// fp_stream_fifo
// Synchronous FIFO with a registered head entry, so the consumer side sees
// only flops.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   push_i, push_data_i   write one entry
//   pop_i                 remove the head entry (ignored when empty)
//   head_valid_o          head entry present
//   head_data_o           head entry (registered)
//   count_o               number of stored entries, 0..DEPTH
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// ---------------------------------------------------------------------------
module fp_stream_fifo
  import fp_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_d;
  logic             head_valid_q;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             full, empty, push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);
  assign count_o = wr_ptr_q - rd_ptr_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wr_ptr_d    = wr_ptr_q + PW'(push_ok);
    rd_ptr_d    = rd_ptr_q + PW'(pop_ok);
    count_d     = wr_ptr_d - rd_ptr_d;
    head_data_d = head_data_q;
    if (count_d != '0) begin
      // If no previously stored entry survives this edge, the new head is
      // the word being written right now (storage is not yet updated).
      if (wr_ptr_q == rd_ptr_d) head_data_d = push_data_i;
      else                      head_data_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= (count_d != '0);
      head_data_q  <= head_data_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which words are
  // meaningful, and leaving the array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_data_q;

endmodule

// File: rtl/fp_stream_adapter.sv
// ---------------------------------------------------------------------------
// fp_stream_adapter
// Valid/ready front-end for a fixed-latency, clock-enable-gated FP operator
// core that sits beside this block. Operands pass straight through to the
// core; a tag shift register marks which core output cycles carry real
// results, and those results are captured into an output FIFO. New operands
// are accepted only while FIFO entries plus in-flight ops stay below DEPTH,
// so every result already has a slot and the core never has to stall.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b   operand handshake
//   out_valid/out_ready/out_data  result handshake (registered)
//   core_ce                       core clock enable (1 once out of reset)
//   core_din0/core_din1           operands to the core
//   core_dout                     result from the core
//   out_count                     pop counter, only with FP_STREAM_STATS_EN
// Parameters: WIDTH, LATENCY (1..MAX_LATENCY), DEPTH (power of two, >= 2).
// Build option: define FP_STREAM_STATS_EN to add the 16-bit out_count port.
// ---------------------------------------------------------------------------
module fp_stream_adapter
  import fp_stream_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             core_ce,
  output logic [WIDTH-1:0] core_din0,
  output logic [WIDTH-1:0] core_din1,
  input  logic [WIDTH-1:0] core_dout
`ifdef FP_STREAM_STATS_EN
  ,
  output logic [15:0]      out_count
`endif
);

  localparam int PW  = ptr_width(DEPTH);
  localparam int IFW = $clog2(MAX_LATENCY + 1);
  localparam int OW  = PW + IFW;

  logic [LATENCY:1] tag_q, tag_d;
  logic             core_ce_q;
  logic             issue, pop;
  logic [PW-1:0]    fifo_count;
  logic [IFW-1:0]   inflight;
  logic [OW-1:0]    occupancy;

  assign core_din0 = in_a;
  assign core_din1 = in_b;
  assign core_ce   = core_ce_q;

  assign issue = in_valid && in_ready;
  assign pop   = out_valid && out_ready;

  // tag[i] set: the op issued i edges ago is still inside the core;
  // tag[LATENCY] set means core_dout holds its result this cycle.
  always_comb begin
    tag_d    = '0;
    tag_d[1] = issue;
    for (int i = 2; i <= LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= LATENCY; i++) inflight = inflight + IFW'(tag_q[i]);
  end

  // Counting in-flight ops as occupied reserves a FIFO slot for each one at
  // issue time. Only registered state feeds this, so in_ready is free of
  // any combinational path from out_ready.
  assign occupancy = OW'(fifo_count) + OW'(inflight);
  assign in_ready  = core_ce_q && (occupancy < OW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q     <= '0;
      core_ce_q <= 1'b0;
    end else begin
      tag_q     <= tag_d;
      core_ce_q <= 1'b1;
    end
  end

  fp_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (tag_q[LATENCY]),
    .push_data_i  (core_dout),
    .pop_i        (pop),
    .head_valid_o (out_valid),
    .head_data_o  (out_data),
    .count_o      (fifo_count)
  );

`ifdef FP_STREAM_STATS_EN
  logic [15:0] out_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   out_count_q <= '0;
    else if (pop) out_count_q <= out_count_q + 16'd1;
  end

  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_fp_stream_adapter.sv
// ---------------------------------------------------------------------------
// tb_fp_stream_adapter
// Bench for fp_stream_adapter with a behavioral single-precision multiplier
// core (LATENCY=5, truncating, normal operands only). Expected results are
// queued when an operand pair is accepted and compared as results pop out.
// Build option: FP_STREAM_STATS_EN also exercises out_count.
// ---------------------------------------------------------------------------
module tb_fp_stream_adapter;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 5;
  localparam int DEPTH   = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             core_ce;
  logic [WIDTH-1:0] core_din0, core_din1, core_dout;
`ifdef FP_STREAM_STATS_EN
  logic [15:0]      out_count;
`endif

  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic [31:0] sb [$];
  bit          tog_run;
  vec_t        tbl [20];

  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal, in-range operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    else       return {s, e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    return {r[31], 8'(100 + $urandom_range(0, 50)), r[22:0]};
  endfunction

  // Behavioral core: samples operands on each enabled edge, result appears
  // LATENCY edges later counting the sampling edge.
  logic [WIDTH-1:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    if (core_ce) begin
      core_pipe[0] <= fmul(core_din0, core_din1);
      for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign core_dout = core_pipe[LATENCY-1];

  fp_stream_adapter #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .core_ce   (core_ce),
    .core_din0 (core_din0),
    .core_din1 (core_din1),
    .core_dout (core_dout)
`ifdef FP_STREAM_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: a pop happens at the next edge, so compare now.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      pops++;
      check("result expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("result data", out_data, sb.pop_front());
    end
  end

  // Offer one operand pair (called #1 after a rising edge); the expected
  // result is queued once acceptance at the coming edge is certain.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit must_now);
    bit accepted;
    accepted = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !accepted; n++) begin
      @(negedge clk);
      if (must_now && n == 0) check("in_ready on offer", 32'(in_ready), 32'd1);
      if (in_ready) begin
        sb.push_back(exp);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("operand accepted", 32'(accepted), 32'd1);
  endtask

  task automatic send_rand(input bit must_now);
    logic [31:0] a, b;
    a = rand_fp();
    b = rand_fp();
    send(a, b, fmul(a, b), must_now);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    check({name, " out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int base;
    int stale;

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    reset     = 1'b0;

    tbl[0] = '{32'h4000_0000, 32'h4080_0000, 32'h4100_0000}; // 2.0 * 4.0
    tbl[1] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000}; // 1.5 * 1.5
    tbl[2] = '{32'h3F80_0000, 32'hC040_0000, 32'hC040_0000}; // 1.0 * -3.0
    for (int i = 3; i < 20; i++) begin
      tbl[i].a   = rand_fp();
      tbl[i].b   = rand_fp();
      tbl[i].exp = fmul(tbl[i].a, tbl[i].b);
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset core_ce", 32'(core_ce), 32'd0);
`ifdef FP_STREAM_STATS_EN
    check("reset out_count", 32'(out_count), 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("in_ready before first edge", 32'(in_ready), 32'd0);
    check("core_ce before first edge", 32'(core_ce), 32'd0);
    @(posedge clk);
    #1;
    check("in_ready after first edge", 32'(in_ready), 32'd1);
    check("core_ce after first edge", 32'(core_ce), 32'd1);

    // Single op: out_valid rises right after edge E+LATENCY
    send(32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 1'b1);
    @(negedge clk);
    check("single out_valid after E", 32'(out_valid), 32'd0);
    repeat (LATENCY - 1) @(posedge clk);
    @(negedge clk);
    check("single out_valid after E+L-1", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("single out_valid after E+L", 32'(out_valid), 32'd1);
    check("single out_data", out_data, 32'h4100_0000);
    @(posedge clk);
    #1;
    drain("single drain");

    // Back-to-back table stream, in_ready must hold high throughout
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b1);
    drain("stream drain");

    // Backpressure: exactly DEPTH accepted with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_rand(1'b1);
    in_a     = rand_fp();
    in_b     = rand_fp();
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("in_ready held low when full", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("full fifo presents data", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready before first pop", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("in_ready after first pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    drain("backpressure drain");

    // Push/pop at the full boundary across several pointer wraps
    tog_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH + 2; i++) send_rand(1'b0);
        tog_run = 1'b0;
      end
      begin
        while (tog_run) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    drain("wrap drain");

    // Reset with 2 results in the FIFO and 3 still in the core
    out_ready = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    send_rand(1'b1);
    send_rand(1'b1);
    send_rand(1'b1);
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid reset in_ready", 32'(in_ready), 32'd0);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", out_data, 32'd0);
    check("mid reset core_ce", 32'(core_ce), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    base      = pops;
    stale     = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no stale results after reset", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    drain("post reset drain");

`ifdef FP_STREAM_STATS_EN
    check("out_count after reset", 32'(out_count), 32'(16'(pops - base)));
    while ((pops - base) + sb.size() < 70000) send_rand(1'b0);
    drain("stats drain");
    check("pops since reset", 32'(pops - base), 32'd70000);
    check("out_count wrapped", 32'(out_count), 32'd4464);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
